// File: rtl/setup_ctrl_pkg.sv
// Shared types and constants for the front-panel setup controller.
package clock_pkg;

    typedef enum logic [1:0] {
        MODE_CLOCK     = 2'd0,
        MODE_TIMER     = 2'd1,
        MODE_STOPWATCH = 2'd2
    } mode_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_EDIT_SEC  = 3'd1,
        ST_EDIT_MIN  = 3'd2,
        ST_EDIT_HOUR = 3'd3,
        ST_COMMIT    = 3'd4
    } state_t;

    localparam logic [7:0] SEC_MAX  = 8'd59;
    localparam logic [7:0] MIN_MAX  = 8'd59;
    localparam logic [7:0] HOUR_MAX = 8'd23;

    localparam int BTN_MODE = 0;
    localparam int BTN_INC  = 1;
    localparam int BTN_SEL  = 2;
    localparam int BTN_RUN  = 3;

    localparam int FIELD_W  = 8;
    localparam int SEC_LSB  = 0;
    localparam int MIN_LSB  = 8;
    localparam int HOUR_LSB = 16;

    // Out-of-range captured values also land on 0, not just the maximum.
    function automatic logic [7:0] incWrap(input logic [7:0] value, input logic [7:0] maxVal);
        return (value >= maxVal) ? 8'd0 : value + 8'd1;
    endfunction

endpackage

// File: rtl/setup_ctrl_if.sv
// Panel-side bus between the raw buttons / counter chain and setup_ctrl.
interface setup_ctrl_if;

    logic [3:0]  button;
    logic [23:0] cur_data;
    logic        zero;
    logic [1:0]  rezhim;
    logic [1:0]  edit_field;
    logic [23:0] edit_data;
    logic        load;
    logic        run_en;

    modport master (
        output button, cur_data, zero,
        input  rezhim, edit_field, edit_data, load, run_en
    );

    modport slave (
        input  button, cur_data, zero,
        output rezhim, edit_field, edit_data, load, run_en
    );

endinterface

// File: rtl/setup_ctrl_button_debounce.sv
// Synchronizes one raw button, accepts a level after DEB_CYCLES stable samples,
// and emits a one-cycle pulse on each accepted rising edge.
module button_debounce #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_levelD;
    logic          r_press;
    logic [CW-1:0] r_cnt;

    // Any sample that agrees with the accepted level restarts the stability count.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_level  <= 1'b0;
            r_levelD <= 1'b0;
            r_press  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1  <= raw;
            r_sync2  <= r_sync1;
            r_levelD <= r_level;
            r_press  <= r_level & ~r_levelD;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign level = r_level;
    assign press = r_press;

endmodule

// File: rtl/setup_ctrl.sv
// Front-panel controller: debounced buttons, mode select, time-edit FSM with a
// single load strobe, and the timer/stopwatch run enable.
module setup_ctrl
    import clock_pkg::*;
#(
    parameter int DEB_CYCLES = 500000
) (
    input  logic         clock,
    input  logic         reset,
    setup_ctrl_if.slave  bus
);

    logic [3:0] w_press;
    logic       w_modeP;
    logic       w_selP;
    logic       w_incP;
    logic       w_runP;

    state_t      r_state;
    mode_t       r_rezhim;
    logic [1:0]  r_editField;
    logic [23:0] r_editData;
    logic        r_load;
    logic        r_runEn;

    for (genvar i = 0; i < 4; i++) begin : g_deb
        button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clock (clock),
            .reset (reset),
            .raw   (bus.button[i]),
            .level (),
            .press (w_press[i])
        );
    end

    // Same-cycle presses resolve to a single winner: mode > select > increment > start/stop.
    always_comb begin
        w_modeP = w_press[BTN_MODE];
        w_selP  = w_press[BTN_SEL] & ~w_press[BTN_MODE];
        w_incP  = w_press[BTN_INC] & ~w_press[BTN_SEL] & ~w_press[BTN_MODE];
        w_runP  = w_press[BTN_RUN] & ~w_press[BTN_INC] & ~w_press[BTN_SEL] & ~w_press[BTN_MODE];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_rezhim    <= MODE_CLOCK;
            r_editField <= 2'd0;
            r_editData  <= 24'd0;
            r_load      <= 1'b0;
            r_runEn     <= 1'b0;
        end else begin
            r_load <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_modeP) begin
                        r_runEn <= 1'b0;
                        case (r_rezhim)
                            MODE_CLOCK: r_rezhim <= MODE_TIMER;
                            MODE_TIMER: r_rezhim <= MODE_STOPWATCH;
                            default:    r_rezhim <= MODE_CLOCK;
                        endcase
                    end else if (w_selP && r_rezhim != MODE_STOPWATCH) begin
                        r_editData  <= bus.cur_data;
                        r_runEn     <= 1'b0;
                        r_editField <= 2'd1;
                        r_state     <= ST_EDIT_SEC;
                    end else if (w_runP && r_rezhim != MODE_CLOCK) begin
                        r_runEn <= ~r_runEn;
                    end else if (r_rezhim == MODE_TIMER && bus.zero && r_runEn) begin
                        r_runEn <= 1'b0;
                    end
                end
                ST_EDIT_SEC, ST_EDIT_MIN, ST_EDIT_HOUR: begin
                    r_runEn <= 1'b0;
                    if (w_modeP) begin
                        r_editField <= 2'd0;
                        r_state     <= ST_IDLE;
                    end else if (w_selP) begin
                        case (r_state)
                            ST_EDIT_SEC: begin
                                r_editField <= 2'd2;
                                r_state     <= ST_EDIT_MIN;
                            end
                            ST_EDIT_MIN: begin
                                r_editField <= 2'd3;
                                r_state     <= ST_EDIT_HOUR;
                            end
                            default: begin
                                r_editField <= 2'd0;
                                r_load      <= 1'b1;
                                r_state     <= ST_COMMIT;
                            end
                        endcase
                    end else if (w_incP) begin
                        case (r_state)
                            ST_EDIT_SEC:
                                r_editData[SEC_LSB +: FIELD_W] <= incWrap(r_editData[SEC_LSB +: FIELD_W], SEC_MAX);
                            ST_EDIT_MIN:
                                r_editData[MIN_LSB +: FIELD_W] <= incWrap(r_editData[MIN_LSB +: FIELD_W], MIN_MAX);
                            default:
                                r_editData[HOUR_LSB +: FIELD_W] <= incWrap(r_editData[HOUR_LSB +: FIELD_W], HOUR_MAX);
                        endcase
                    end
                end
                default: begin
                    r_runEn     <= 1'b0;
                    r_editField <= 2'd0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.rezhim     = r_rezhim;
    assign bus.edit_field = r_editField;
    assign bus.edit_data  = r_editData;
    assign bus.load       = r_load;
    assign bus.run_en     = r_runEn;

endmodule

// File: tb/tb_setup_ctrl.sv
// Directed bench for setup_ctrl with a short debounce window (DEB_CYCLES=4).
module tb_setup_ctrl;

    logic clock;
    logic reset;
    int   nAsserts;
    int   nFails;
    int   loads;

    setup_ctrl_if bus();

    setup_ctrl #(.DEB_CYCLES(4)) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nAsserts++;
        assert (observed === expected)
        else begin
            nFails++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Holds the buttons for 10 clocks, releases, and lets the release settle; counts load cycles.
    task automatic applyStimulus(input logic [3:0] mask, output int loadCount);
        loadCount = 0;
        @(posedge clock);
        #1 bus.button = mask;
        for (int c = 1; c <= 18; c++) begin
            @(posedge clock);
            if (c == 10) #1 bus.button = 4'b0000;
            @(negedge clock);
            if (bus.load === 1'b1) loadCount++;
        end
    endtask

    initial begin
        nAsserts     = 0;
        nFails       = 0;
        reset        = 1'b0;
        bus.button   = 4'b0000;
        bus.cur_data = 24'h000000;
        bus.zero     = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checkOutput("reset rezhim", 32'(bus.rezhim), 32'd0);
        checkOutput("reset edit_field", 32'(bus.edit_field), 32'd0);
        checkOutput("reset edit_data", 32'(bus.edit_data), 32'h0);
        checkOutput("reset load", 32'(bus.load), 32'd0);
        checkOutput("reset run_en", 32'(bus.run_en), 32'd0);
        reset = 1'b1;
        repeat (2) @(posedge clock);

        // Press latency: press pulse after edge 7, FSM reacts on edge 8.
        @(posedge clock);
        #1 bus.button = 4'b0001;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clock);
            @(negedge clock);
            if (c == 7) checkOutput("latency rezhim edge7", 32'(bus.rezhim), 32'd0);
            if (c == 8) checkOutput("latency rezhim edge8", 32'(bus.rezhim), 32'd1);
        end
        repeat (6) @(posedge clock);
        @(negedge clock);
        checkOutput("held mode no repeat", 32'(bus.rezhim), 32'd1);
        #1 bus.button = 4'b0000;
        repeat (10) @(posedge clock);
        @(negedge clock);
        checkOutput("mode1 run_en", 32'(bus.run_en), 32'd0);

        applyStimulus(4'b0001, loads);
        checkOutput("mode2 rezhim", 32'(bus.rezhim), 32'd2);
        checkOutput("mode2 run_en", 32'(bus.run_en), 32'd0);
        applyStimulus(4'b0001, loads);
        checkOutput("mode3 rezhim", 32'(bus.rezhim), 32'd0);
        checkOutput("mode3 run_en", 32'(bus.run_en), 32'd0);

        // Full edit from 23:59:58 rolls every field to zero.
        bus.cur_data = 24'h173B3A;
        applyStimulus(4'b0100, loads);
        checkOutput("edit sec field", 32'(bus.edit_field), 32'd1);
        checkOutput("edit capture", 32'(bus.edit_data), 32'h173B3A);

        @(posedge clock);
        #1 bus.button = 4'b0010;
        repeat (3) @(posedge clock);
        #1 bus.button = 4'b0000;
        repeat (12) @(posedge clock);
        @(negedge clock);
        checkOutput("glitch ignored", 32'(bus.edit_data), 32'h173B3A);

        applyStimulus(4'b0010, loads);
        checkOutput("inc sec 59", 32'(bus.edit_data), 32'h173B3B);
        applyStimulus(4'b0010, loads);
        checkOutput("inc sec wrap", 32'(bus.edit_data), 32'h173B00);
        applyStimulus(4'b0100, loads);
        checkOutput("edit min field", 32'(bus.edit_field), 32'd2);
        applyStimulus(4'b0010, loads);
        checkOutput("inc min wrap", 32'(bus.edit_data), 32'h170000);
        applyStimulus(4'b0100, loads);
        checkOutput("edit hour field", 32'(bus.edit_field), 32'd3);
        applyStimulus(4'b0010, loads);
        checkOutput("inc hour wrap", 32'(bus.edit_data), 32'h000000);
        checkOutput("no early load", 32'(loads), 32'd0);
        applyStimulus(4'b0100, loads);
        checkOutput("commit load count", 32'(loads), 32'd1);
        checkOutput("commit edit_field", 32'(bus.edit_field), 32'd0);
        checkOutput("commit edit_data", 32'(bus.edit_data), 32'h000000);
        checkOutput("commit run_en", 32'(bus.run_en), 32'd0);

        // Abort from EDIT_MIN.
        bus.cur_data = 24'h0A1B2C;
        applyStimulus(4'b0100, loads);
        applyStimulus(4'b0100, loads);
        checkOutput("abort in min", 32'(bus.edit_field), 32'd2);
        applyStimulus(4'b0001, loads);
        checkOutput("abort edit_field", 32'(bus.edit_field), 32'd0);
        checkOutput("abort rezhim", 32'(bus.rezhim), 32'd0);
        checkOutput("abort no load", 32'(loads), 32'd0);
        applyStimulus(4'b1000, loads);
        checkOutput("run ignored clock", 32'(bus.run_en), 32'd0);

        // Timer run, expiry, and simultaneous mode+run.
        applyStimulus(4'b0001, loads);
        checkOutput("timer rezhim", 32'(bus.rezhim), 32'd1);
        applyStimulus(4'b1000, loads);
        checkOutput("timer start", 32'(bus.run_en), 32'd1);
        @(posedge clock);
        #1 bus.zero = 1'b1;
        @(negedge clock);
        checkOutput("zero before edge", 32'(bus.run_en), 32'd1);
        @(posedge clock);
        @(negedge clock);
        checkOutput("zero clears run", 32'(bus.run_en), 32'd0);
        #1 bus.zero = 1'b0;
        applyStimulus(4'b1000, loads);
        checkOutput("timer restart", 32'(bus.run_en), 32'd1);
        applyStimulus(4'b1001, loads);
        checkOutput("simul rezhim", 32'(bus.rezhim), 32'd2);
        checkOutput("simul run_en", 32'(bus.run_en), 32'd0);
        applyStimulus(4'b0100, loads);
        checkOutput("select ignored sw", 32'(bus.edit_field), 32'd0);

        // Asynchronous reset in the middle of EDIT_HOUR.
        applyStimulus(4'b0001, loads);
        bus.cur_data = 24'h0C1E2D;
        applyStimulus(4'b0100, loads);
        applyStimulus(4'b0100, loads);
        applyStimulus(4'b0100, loads);
        applyStimulus(4'b0010, loads);
        checkOutput("hour edit value", 32'(bus.edit_data), 32'h0D1E2D);
        checkOutput("hour edit field", 32'(bus.edit_field), 32'd3);
        @(posedge clock);
        #3 reset = 1'b0;
        #1;
        checkOutput("async rst edit_field", 32'(bus.edit_field), 32'd0);
        checkOutput("async rst edit_data", 32'(bus.edit_data), 32'h0);
        checkOutput("async rst rezhim", 32'(bus.rezhim), 32'd0);
        checkOutput("async rst load", 32'(bus.load), 32'd0);
        #12 reset = 1'b1;
        loads = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (bus.load === 1'b1) loads++;
        end
        checkOutput("no load after reset", 32'(loads), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule

// File: doc/setup_ctrl.md
# setup_ctrl

Front-panel controller for the clock/timer datapath. It debounces the four panel buttons and selects the operating mode. It runs the time-setting state machine, which edits seconds, minutes and hours in turn, then issues a single load strobe with the edited value to the sec/min/hour counter chain. It also owns the timer start/stop level. It sits between the raw button pins and the counter chain, replacing ad-hoc per-button logic in the top level.

## Interface
Parameters:
- DEB_CYCLES, 500000: consecutive stable samples required to accept a button level (10 ms at 50 MHz).

Ports:
- clock  in  1  system clock, all logic on posedge.
- reset  in  1  asynchronous, active-low reset.
- button  in  4  raw buttons, active-high:
  - [0] mode
  - [1] increment
  - [2] select/confirm
  - [3] start/stop
- cur_data  in  24  live time {hour[23:16], min[15:8], sec[7:0]}, binary.
- zero  in  1  high while timer value is 0.
- rezhim  out  2  mode: 0 clock, 1 timer, 2 stopwatch; 3 never driven.
- edit_field  out  2  0 none, 1 sec, 2 min, 3 hour.
- edit_data  out  24  value being edited, same format as cur_data.
- load  out  1  one-cycle strobe; the counters take edit_data when high.
- run_en  out  1  timer/stopwatch count enable.

## Operation
- Debounce, per button:
  - 2-FF synchronizer feeds a stability counter.
  - Debounced level updates after DEB_CYCLES consecutive equal samples.
  - Press = one-cycle pulse on the rising edge of the debounced level. Releases produce nothing.
- Simultaneous presses in one cycle: priority mode > select > increment > start/stop. Only the winner is acted on; the others are dropped.
- FSM states: IDLE, EDIT_SEC, EDIT_MIN, EDIT_HOUR, COMMIT.
- IDLE:
  - Mode press: rezhim 0→1→2→0, and run_en cleared.
  - Select press in rezhim 0 or 1: edit_data ← cur_data, run_en ← 0, go to EDIT_SEC. Select in rezhim 2 is ignored.
  - Start/stop press in rezhim 1 or 2: run_en toggles. Ignored in rezhim 0.
- EDIT_x:
  - Increment press: field +1, wrapping at its maximum (sec/min 59→0, hour 23→0).
  - Other fields are untouched by an increment.
  - Captured field values above the maximum wrap to 0 on the first increment.
  - Select press: SEC→MIN→HOUR→COMMIT.
  - Mode press: abort to IDLE with no load; rezhim unchanged.
  - Start/stop press is ignored.
- COMMIT: load=1 for exactly one cycle, then IDLE. run_en stays 0.
- edit_field: 1/2/3 in EDIT_SEC/MIN/HOUR, 0 otherwise.
- Timer expiry: in rezhim 1, zero=1 while run_en=1 clears run_en on the next edge.
- run_en is forced 0 in all states except IDLE.
- In rezhim 0, run_en is a don't-care and is held 0.

## Timing
- Reset values: rezhim=0, edit_field=0, edit_data=0, load=0, run_en=0, FSM=IDLE.
- Reset also clears the debounce counters and debounced levels (to 0) and the synchronizers.
- Reset asserted mid-edit discards the edit and produces no load.
- Press latency: a raw rising edge held stable produces the press pulse 2+DEB_CYCLES+1 clocks later.
- Registered outputs react on the edge after the press pulse.
- Load timing: load asserts one cycle after the HOUR-state select press is registered. edit_data is stable from entry to EDIT_SEC until load deasserts.
- One press = one action. Holding a button gives no auto-repeat.
- Glitches shorter than DEB_CYCLES are never accepted.

## Structure
- Package clock_pkg holds:
  - the mode enum: MODE_CLOCK=0, MODE_TIMER=1, MODE_STOPWATCH=2
  - the FSM state enum
  - SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23
  - button index constants BTN_MODE=0, BTN_INC=1, BTN_SEL=2, BTN_RUN=3
  - field slice constants for the 24-bit word
- Sub-module button_debounce (parameter DEB_CYCLES; ports clock, reset, raw, level, press), instantiated four times.

## Test plan
All scenarios use DEB_CYCLES=4.
- Debounce:
  - 3-cycle glitch on button[1] → no press.
  - Press held for 10 cycles → exactly one press, 7 cycles after the raw edge.
- Mode cycling: three mode presses → rezhim 1, 2, 0; run_en=0 after each.
- Full edit:
  - Setup: rezhim=0, cur_data=0x17_3B_3A (23:59:58).
  - Stimulus: select; increment ×2; select; increment; select; increment; select.
  - Required: edit_data=0x00_00_00 with edit_field sequence 1,2,3, then one load pulse; run_en=0.
- Abort: in EDIT_MIN, mode press → IDLE, no load, rezhim unchanged, edit_field=0.
- Timer:
  - rezhim=1, start/stop press → run_en=1.
  - zero=1 → run_en=0 next edge.
  - Simultaneous mode+start/stop press → only rezhim advances, to 2.
- Reset: async reset mid-EDIT_HOUR → all outputs at reset values immediately; no load afterwards.
